target_generator: RTL

- Produces the target (food) cell address consumed by the snake control block as TARGET_ADDR_H / TARGET_ADDR_V, on the 160x120 game grid (4x4-pixel cells on the 640x480 VGA frame).
- Regenerates a pseudo-random, in-range target whenever the snake reaches the current one, and whenever the master state machine enters PLAY.
- Sits between the master state machine / snake control block (trigger sources) and the snake control and score blocks (consumers).

---
 rtl/target_generator.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/target_generator.sv
// -----------------------------------------------------------------------------
// target_generator
//
// Purpose:
//   Holds the snake game's target (food) cell on the 160x120 grid of 4x4-pixel
//   cells that cover the 640x480 VGA frame. A new pseudo-random target is
//   searched for whenever the snake head reaches the current one, and whenever
//   the master state machine enters PLAY. Two free-running LFSRs supply the
//   candidate coordinates. Each candidate is checked against the grid limits
//   and against the current target. If no acceptable candidate turns up within
//   a bounded number of tries, a deterministic column step is used instead.
//
// Ports:
//   CLK             in   1  system clock (100 MHz)
//   RESET           in   1  synchronous, active-low reset
//   MSM_STATE       in   2  master state: 00 idle, 01 play, 10 win, 11 lost
//   TARGET_REACHED  in   1  level from snake control, high while head is on target
//   TARGET_ADDR_H   out  8  current target column, 0..MAX_X
//   TARGET_ADDR_V   out  7  current target row, 0..MAX_Y
//   NEW_TARGET      out  1  one-cycle pulse when the target address is updated
//   BUSY            out  1  high while a new target is being searched for
// -----------------------------------------------------------------------------
module target_generator #(
  parameter int         MAX_X         = 159,
  parameter int         MAX_Y         = 119,
  parameter int         INIT_H        = 40,
  parameter int         INIT_V        = 30,
  parameter logic [7:0] SEED_H        = 8'hB5,
  parameter logic [6:0] SEED_V        = 7'h5A,
  parameter int         MAX_TRIES     = 64,
  parameter int         FALLBACK_STEP = 37
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] MSM_STATE,
  input  logic       TARGET_REACHED,
  output logic [7:0] TARGET_ADDR_H,
  output logic [6:0] TARGET_ADDR_V,
  output logic       NEW_TARGET,
  output logic       BUSY
);

  localparam logic [1:0] MSM_PLAY = 2'b01;

  localparam logic [0:0] ST_HOLD   = 1'b0;
  localparam logic [0:0] ST_SEARCH = 1'b1;

  // An all-zero seed would lock a Fibonacci LFSR at zero forever.
  localparam logic [7:0] SEED_H_NZ = (SEED_H == 8'd0) ? 8'd1 : SEED_H;
  localparam logic [6:0] SEED_V_NZ = (SEED_V == 7'd0) ? 7'd1 : SEED_V;

  localparam logic [7:0] MAX_X_W  = 8'(MAX_X);
  localparam logic [6:0] MAX_Y_W  = 7'(MAX_Y);
  localparam logic [7:0] INIT_H_W = 8'(INIT_H);
  localparam logic [6:0] INIT_V_W = 7'(INIT_V);

  localparam int                 TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0]   LAST_TRY = TRY_W'(MAX_TRIES - 1);

  localparam logic [8:0] STEP_W = 9'(FALLBACK_STEP);
  localparam logic [8:0] MOD_W  = 9'(MAX_X + 1);

  logic [7:0]       lfsr_h;
  logic [6:0]       lfsr_v;
  logic             reached_q;
  logic [1:0]       msm_q;
  logic [0:0]       state;
  logic [TRY_W-1:0] tries;

  logic [7:0] cand_h;
  logic [6:0] cand_v;
  logic       cand_valid;
  logic       play_now;
  logic       trig_reach;
  logic       trig_start;
  logic       trigger;
  logic [8:0] fb_sum;
  logic [7:0] fb_h;

  // Free-running LFSRs.
  // H taps x^8+x^6+x^5+x^4+1. V taps x^7+x^6+1.
  // Both sequences are maximal length, so an LFSR seeded non-zero never hits 0.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      lfsr_h <= SEED_H_NZ;
      lfsr_v <= SEED_V_NZ;
    end else begin
      lfsr_h <= {lfsr_h[6:0], lfsr_h[7] ^ lfsr_h[5] ^ lfsr_h[4] ^ lfsr_h[3]};
      lfsr_v <= {lfsr_v[5:0], lfsr_v[6] ^ lfsr_v[5]};
    end
  end

  // Edge-detect history for the reach level and the master state.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      reached_q <= 1'b0;
      msm_q     <= 2'b00;
    end else begin
      reached_q <= TARGET_REACHED;
      msm_q     <= MSM_STATE;
    end
  end

  // Subtracting 1 lets candidates reach 0, which an LFSR value cannot.
  // The range check uses the full LFSR width, so large values are rejected
  // rather than wrapped into range.
  always_comb begin
    cand_h     = lfsr_h - 8'd1;
    cand_v     = lfsr_v - 7'd1;
    cand_valid = (cand_h <= MAX_X_W) && (cand_v <= MAX_Y_W) &&
                 ({cand_h, cand_v} != {TARGET_ADDR_H, TARGET_ADDR_V});
  end

  // A reach and a game start in the same cycle form a single trigger.
  always_comb begin
    play_now   = (MSM_STATE == MSM_PLAY);
    trig_reach = TARGET_REACHED && !reached_q && play_now;
    trig_start = play_now && (msm_q != MSM_PLAY);
    trigger    = trig_reach || trig_start;
  end

  // The fallback sum is formed at 9 bits, so H + step cannot overflow before
  // the modulo brings it back onto the grid.
  always_comb begin
    fb_sum = {1'b0, TARGET_ADDR_H} + STEP_W;
    fb_h   = 8'(fb_sum % MOD_W);
  end

  // Search controller.
  // Leaving PLAY aborts the search and takes priority over a good candidate.
  // Triggers seen during SEARCH are dropped, not queued.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state         <= ST_HOLD;
      tries         <= '0;
      TARGET_ADDR_H <= INIT_H_W;
      TARGET_ADDR_V <= INIT_V_W;
      NEW_TARGET    <= 1'b0;
    end else begin
      NEW_TARGET <= 1'b0;
      if (state == ST_HOLD) begin
        if (trigger) begin
          state <= ST_SEARCH;
          tries <= '0;
        end
      end else begin
        if (!play_now) begin
          state <= ST_HOLD;
        end else if (cand_valid) begin
          TARGET_ADDR_H <= cand_h;
          TARGET_ADDR_V <= cand_v;
          NEW_TARGET    <= 1'b1;
          state         <= ST_HOLD;
        end else if (tries == LAST_TRY) begin
          TARGET_ADDR_H <= fb_h;
          NEW_TARGET    <= 1'b1;
          state         <= ST_HOLD;
        end else begin
          tries <= tries + TRY_W'(1);
        end
      end
    end
  end

  assign BUSY = (state == ST_SEARCH);

endmodule
